ctrl_sequencer: RTL and testbench

- Fetch/decode/execute control FSM for the 4-bit accumulator CPU.
- Sits directly upstream of the datapath registers (PC, AR, IR, AC) and drives their inc/load/clr strobes, ALU op select and memory read/write.
- Consumes the IR opcode field, the AC zero flag and the memory ready handshake.
- One instruction is in flight at a time; there is no pipelining.

---
 rtl/ctrl_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetch/decode/execute control FSM for the 4-bit accumulator CPU.
// Drives datapath register strobes, ALU op select and memory requests, one
// instruction at a time, with a bounded wait on the memory ready handshake.
module ctrl_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter logic [3:0]  HALT_OPC    = 4'hF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       ac_zero,
  input  logic       mem_ready,
  output logic       ar_sel,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       ar_load,
  output logic       ir_load,
  output logic       ac_load,
  output logic       ac_inc,
  output logic       ac_clr,
  output logic [1:0] alu_op,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    FETCH_A = 3'd0,
    FETCH_M = 3'd1,
    DECODE  = 3'd2,
    EXEC_RD = 3'd3,
    EXEC_WR = 3'd4,
    HALT    = 3'd5,
    FAULT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_AND  = 2'b10
  } alu_t;

  localparam logic [3:0] OPC_LDA = 4'h1;
  localparam logic [3:0] OPC_STA = 4'h2;
  localparam logic [3:0] OPC_ADD = 4'h3;
  localparam logic [3:0] OPC_AND = 4'h4;
  localparam logic [3:0] OPC_JMP = 4'h5;
  localparam logic [3:0] OPC_JZ  = 4'h6;
  localparam logic [3:0] OPC_INC = 4'h7;
  localparam logic [3:0] OPC_CLA = 4'h8;

  // Count value in the last permitted wait cycle; no ready there means FAULT.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  alu_t       exec_op;
  logic       wait_expired;

  assign wait_expired = (wait_cnt == WAIT_LAST);

  // State sequencing, wait counter and the ALU op captured at decode time.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= FETCH_A;
      wait_cnt <= '0;
      exec_op  <= ALU_PASS;
    end else begin
      case (state)
        FETCH_A: begin
          if (run) begin
            state    <= FETCH_M;
            wait_cnt <= '0;
          end
        end
        FETCH_M, EXEC_RD, EXEC_WR: begin
          if (mem_ready) begin
            state <= (state == FETCH_M) ? DECODE : FETCH_A;
          end else if (wait_expired) begin
            state <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DECODE: begin
          wait_cnt <= '0;
          if (opcode == HALT_OPC) begin
            state <= HALT;
          end else begin
            case (opcode)
              OPC_LDA: begin state <= EXEC_RD; exec_op <= ALU_PASS; end
              OPC_ADD: begin state <= EXEC_RD; exec_op <= ALU_ADD;  end
              OPC_AND: begin state <= EXEC_RD; exec_op <= ALU_AND;  end
              OPC_STA: state <= EXEC_WR;
              default: state <= FETCH_A;
            endcase
          end
        end
        HALT:    state <= HALT;
        FAULT:   state <= FAULT;
        default: state <= FETCH_A;
      endcase
    end
  end

  // Strobes and status decoded from state and inputs; clr forces everything low.
  always_comb begin
    ar_sel    = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    ar_load   = 1'b0;
    ir_load   = 1'b0;
    ac_load   = 1'b0;
    ac_inc    = 1'b0;
    ac_clr    = 1'b0;
    alu_op    = ALU_PASS;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    state_dbg = '0;
    if (!clr) begin
      state_dbg = state;
      case (state)
        FETCH_A: ar_load = run;
        FETCH_M: begin
          mem_rd  = 1'b1;
          ir_load = mem_ready;
          pc_inc  = mem_ready;
        end
        DECODE: begin
          if (opcode != HALT_OPC) begin
            case (opcode)
              OPC_LDA, OPC_STA, OPC_ADD, OPC_AND: begin
                ar_sel  = 1'b1;
                ar_load = 1'b1;
              end
              OPC_JMP: pc_load = 1'b1;
              OPC_JZ:  pc_load = ac_zero;
              OPC_INC: ac_inc  = 1'b1;
              OPC_CLA: ac_clr  = 1'b1;
              default: ;
            endcase
          end
        end
        EXEC_RD: begin
          mem_rd  = 1'b1;
          alu_op  = exec_op;
          ac_load = mem_ready;
        end
        EXEC_WR: mem_wr = 1'b1;
        HALT:    halted = 1'b1;
        FAULT:   fault  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: randomized self-checking bench for ctrl_sequencer.
// Expected behaviour is generated per instruction as a cycle trace of
// (inputs, expected outputs), then played against the DUT.
module tb_ctrl_sequencer;

  localparam int unsigned TB_T    = 8;
  localparam logic [3:0]  TB_HALT = 4'hF;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = '0;
  logic       ac_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ar_sel, pc_inc, pc_load, ar_load, ir_load, ac_load, ac_inc, ac_clr;
  logic [1:0] alu_op;
  logic       mem_rd, mem_wr, halted, fault;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  ctrl_sequencer #(.MEM_TIMEOUT(TB_T), .HALT_OPC(TB_HALT)) dut (
    .clk(clk), .clr(clr), .run(run), .opcode(opcode), .ac_zero(ac_zero),
    .mem_ready(mem_ready), .ar_sel(ar_sel), .pc_inc(pc_inc), .pc_load(pc_load),
    .ar_load(ar_load), .ir_load(ir_load), .ac_load(ac_load), .ac_inc(ac_inc),
    .ac_clr(ac_clr), .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .halted(halted), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       clr;
    logic       run;
    logic [3:0] opc;
    logic       acz;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic       ar_sel, pc_inc, pc_load, ar_load, ir_load, ac_load, ac_inc, ac_clr;
    logic [1:0] alu_op;
    logic       mem_rd, mem_wr, halted, fault;
    logic [2:0] st;
  } outv_t;

  stim_t stim_q[$];
  outv_t exp_q[$];
  outv_t obs;

  function automatic stim_t rnd_stim();
    stim_t s;
    s.clr = 1'b0;
    s.run = 1'($urandom);
    s.opc = 4'($urandom);
    s.acz = 1'($urandom);
    s.rdy = 1'($urandom);
    return s;
  endfunction

  function automatic outv_t blank(input logic [2:0] st);
    outv_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic void push(input stim_t s, input outv_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  function automatic void push_idle(input int unsigned n);
    stim_t s;
    for (int unsigned k = 0; k < n; k++) begin
      s = rnd_stim();
      s.run = 1'b0;
      push(s, blank(3'd0));
    end
  endfunction

  function automatic void push_clr();
    stim_t s = rnd_stim();
    s.clr = 1'b1;
    push(s, '0);
  endfunction

  // Cycles stuck in HALT (5) or FAULT (6); inputs random, nothing may move.
  function automatic void push_stuck(input logic [2:0] st, input int unsigned n);
    outv_t e;
    for (int unsigned k = 0; k < n; k++) begin
      e = blank(st);
      e.halted = (st == 3'd5);
      e.fault  = (st == 3'd6);
      push(rnd_stim(), e);
    end
  endfunction

  // Memory wait cycles for one access; returns 1 if the access times out,
  // in which case the first FAULT cycle has also been queued.
  function automatic bit mem_waits(input logic [2:0] st, input int unsigned waits,
                                   input bit wr, input logic [1:0] alu);
    stim_t s;
    outv_t e;
    for (int unsigned k = 0; k < waits && k < TB_T; k++) begin
      s = rnd_stim();
      s.rdy = 1'b0;
      e = blank(st);
      e.mem_rd = !wr;
      e.mem_wr = wr;
      e.alu_op = alu;
      push(s, e);
    end
    if (waits >= TB_T) begin
      push_stuck(3'd6, 1);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // One instruction from FETCH_A; wf/we = memory wait cycles for fetch/execute.
  // Returns 0 normal completion, 1 fault, 2 halt.
  function automatic int model_instr(input logic [3:0] o, input logic acz,
                                     input int unsigned wf, input int unsigned we);
    stim_t s;
    outv_t e;
    logic [1:0] alu;
    s = rnd_stim(); s.run = 1'b1;
    e = blank(3'd0); e.ar_load = 1'b1;
    push(s, e);
    if (mem_waits(3'd1, wf, 1'b0, 2'b00)) return 1;
    s = rnd_stim(); s.rdy = 1'b1;
    e = blank(3'd1); e.mem_rd = 1'b1; e.ir_load = 1'b1; e.pc_inc = 1'b1;
    push(s, e);
    s = rnd_stim(); s.opc = o; s.acz = acz;
    e = blank(3'd2);
    if (o == TB_HALT) begin
      push(s, e);
      push_stuck(3'd5, 1);
      return 2;
    end
    case (o)
      4'h1, 4'h2, 4'h3, 4'h4: begin e.ar_sel = 1'b1; e.ar_load = 1'b1; end
      4'h5: e.pc_load = 1'b1;
      4'h6: e.pc_load = acz;
      4'h7: e.ac_inc  = 1'b1;
      4'h8: e.ac_clr  = 1'b1;
      default: ;
    endcase
    push(s, e);
    if (o == 4'h1 || o == 4'h3 || o == 4'h4) begin
      alu = (o == 4'h1) ? 2'b00 : (o == 4'h3) ? 2'b01 : 2'b10;
      if (mem_waits(3'd3, we, 1'b0, alu)) return 1;
      s = rnd_stim(); s.rdy = 1'b1;
      e = blank(3'd3); e.mem_rd = 1'b1; e.alu_op = alu; e.ac_load = 1'b1;
      push(s, e);
    end else if (o == 4'h2) begin
      if (mem_waits(3'd4, we, 1'b1, 2'b00)) return 1;
      s = rnd_stim(); s.rdy = 1'b1;
      e = blank(3'd4); e.mem_wr = 1'b1;
      push(s, e);
    end
    return 0;
  endfunction

  function automatic int unsigned rnd_wait();
    int unsigned r = $urandom_range(19, 0);
    if (r < 12) return 0;
    if (r < 18) return $urandom_range(TB_T - 1, 1);
    return TB_T;
  endfunction

  function automatic void clear_q();
    stim_q.delete();
    exp_q.delete();
  endfunction

  // Drive one cycle's inputs after the falling edge and sample outputs mid-low-phase.
  task automatic drive_cycle(input stim_t s, output outv_t o);
    @(negedge clk);
    clr       = s.clr;
    run       = s.run;
    opcode    = s.opc;
    ac_zero   = s.acz;
    mem_ready = s.rdy;
    #2;
    o = {ar_sel, pc_inc, pc_load, ar_load, ir_load, ac_load, ac_inc, ac_clr,
         alu_op, mem_rd, mem_wr, halted, fault, state_dbg};
  endtask

  task automatic test_reset();
    clear_q();
    push_clr();
    push_clr();
    push_idle(5);
    for (int i = 0; i < exp_q.size(); i++) begin
      drive_cycle(stim_q[i], obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL reset cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_fetch_lda();
    int r;
    clear_q();
    r = model_instr(4'h1, 1'b0, 0, 0);
    push_idle(1);
    for (int i = 0; i < exp_q.size(); i++) begin
      drive_cycle(stim_q[i], obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL fetch_lda cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
    end
    checks++;
    if (r != 0 || exp_q.size() != 5) begin
      errors++;
      $display("FAIL fetch_lda_len: status %0d len %0d, required 0 and 5", r, exp_q.size());
    end
  endtask

  task automatic test_jz();
    int r;
    clear_q();
    r = model_instr(4'h6, 1'b1, 0, 0);
    r = model_instr(4'h6, 1'b0, 0, 0);
    push_idle(1);
    for (int i = 0; i < exp_q.size(); i++) begin
      drive_cycle(stim_q[i], obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL jz cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_wait_timeout();
    int r;
    clear_q();
    r = model_instr(4'h2, 1'b0, 0, 3);
    r = model_instr(4'h3, 1'b0, 2, TB_T - 1);
    r = model_instr(4'h4, 1'b0, TB_T - 1, 1);
    r = model_instr(4'h1, 1'b0, TB_T, 0);
    push_stuck(3'd6, 3);
    push_clr();
    r = model_instr(4'h1, 1'b0, 0, TB_T);
    push_stuck(3'd6, 2);
    push_clr();
    r = model_instr(4'h2, 1'b0, 1, TB_T);
    push_stuck(3'd6, 2);
    push_clr();
    push_idle(1);
    for (int i = 0; i < exp_q.size(); i++) begin
      drive_cycle(stim_q[i], obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL wait_timeout cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_halt();
    int r;
    clear_q();
    r = model_instr(TB_HALT, 1'b0, 1, 0);
    push_stuck(3'd5, 6);
    push_clr();
    push_idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      drive_cycle(stim_q[i], obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL halt cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_clr_mid();
    stim_t s;
    outv_t e;
    clear_q();
    s = rnd_stim(); s.run = 1'b1;
    e = blank(3'd0); e.ar_load = 1'b1;
    push(s, e);
    s = rnd_stim(); s.rdy = 1'b0;
    e = blank(3'd1); e.mem_rd = 1'b1;
    push(s, e);
    s = rnd_stim(); s.rdy = 1'b0; s.clr = 1'b1;
    push(s, '0);
    push_idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      drive_cycle(stim_q[i], obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL clr_mid cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_random_program();
    int r;
    clear_q();
    for (int n = 0; n < 60; n++) begin
      push_idle($urandom_range(2, 0));
      r = model_instr(4'($urandom), 1'($urandom), rnd_wait(), rnd_wait());
      if (r == 1) push_stuck(3'd6, 2);
      if (r == 2) push_stuck(3'd5, 2);
      if (r != 0) push_clr();
    end
    push_idle(1);
    for (int i = 0; i < exp_q.size(); i++) begin
      drive_cycle(stim_q[i], obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL random cycle %0d: stim %b got %b expected %b",
                 i, stim_q[i], obs, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_lda();
    test_jz();
    test_wait_timeout();
    test_halt();
    test_clr_mid();
    test_random_program();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
